// File: rtl/write_buffer_pkg.sv
// Shared definitions for the posted-write buffer: FSM state encoding and default geometry.
package write_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } wb_state_e;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 10;
  localparam int WB_DW    = 32;

endpackage

// File: rtl/write_buffer_if.sv
// CPU request port and memory port of the write buffer, bundled as one interface.
interface write_buffer_if
  import write_buffer_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW
);
  logic          cpu_we;
  logic          cpu_re;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  // The buffer itself: accepts CPU requests, drives the memory strobes.
  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_stall, mem_we, mem_re, mem_addr, mem_wdata
  );

  // The surroundings: CPU pipeline plus the memory responder.
  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_stall, mem_we, mem_re, mem_addr, mem_wdata
  );

endinterface

// File: rtl/write_buffer_fifo.sv
// wb_fifo: DEPTH-entry {addr,data} store queue. With WB_FWD_EN it also exposes every entry
// in age order (index 0 = oldest) for load forwarding.
module wb_fifo
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [AW-1:0]    in_addr,
  input  logic [DW-1:0]    in_data,
`ifdef WB_FWD_EN
  output logic [AW-1:0]    ent_addr [DEPTH],
  output logic [DW-1:0]    ent_data [DEPTH],
  output logic [DEPTH-1:0] ent_vld,
`endif
  output logic [AW-1:0]    head_addr,
  output logic [DW-1:0]    head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage carries no reset; validity is defined purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

`ifdef WB_FWD_EN
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] idx;
    assign idx         = rd_ptr + PW'(i);
    assign ent_addr[i] = addr_mem[idx];
    assign ent_data[i] = data_mem[idx];
    assign ent_vld[i]  = (CW'(i) < count);
  end
`endif

endmodule

// File: rtl/write_buffer.sv
// write_buffer: posted-write buffer between the CPU request port and slow data memory.
// Define WB_FWD_EN to forward buffered store data to loads and let load misses bypass pending stores.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input logic           clk,
  input logic           rst,
  write_buffer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_e     state;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic          ld_req, rd_done, fwd_hit, ld_issue;
  logic [AW-1:0] head_addr, mem_addr_q;
  logic [DW-1:0] head_data, mem_wdata_q, fwd_data, rdata_q;
  logic          mem_we_q, mem_re_q, stall;

  // A simultaneous store and load is handled as the store alone.
  assign ld_req  = bus.cpu_re & ~bus.cpu_we;
  assign push    = bus.cpu_we & ~full;
  assign pop     = (state == WRITE) & bus.mem_ready;
  assign rd_done = (state == READ) & bus.mem_ready;

`ifdef WB_FWD_EN
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .in_addr   (bus.cpu_addr),
    .in_data   (bus.cpu_wdata),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .ent_vld   (ent_vld),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Scanning oldest to youngest lets the youngest matching store win.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == bus.cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[i];
      end
    end
  end

  assign ld_issue = ld_req & ~fwd_hit;
`else
  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .in_addr   (bus.cpu_addr),
    .in_data   (bus.cpu_wdata),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Without forwarding a load must wait for the buffer to drain completely.
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  assign ld_issue = ld_req & empty;
`endif

  always_comb begin
    stall = 1'b0;
    if (bus.cpu_we)      stall = full;
    else if (bus.cpu_re) stall = ~(fwd_hit | rd_done);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_issue) begin
            state      <= READ;
            mem_re_q   <= 1'b1;
            mem_addr_q <= bus.cpu_addr;
          end else if (!empty) begin
            state       <= WRITE;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= head_addr;
            mem_wdata_q <= head_data;
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            state    <= IDLE;
            mem_we_q <= 1'b0;
          end
        end
        READ: begin
          if (bus.mem_ready) begin
            state    <= IDLE;
            mem_re_q <= 1'b0;
            rdata_q  <= bus.mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_stall = stall;
  assign bus.cpu_rdata = rd_done ? bus.mem_rdata : ((fwd_hit & ld_req) ? fwd_data : rdata_q);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: scoreboard of expected memory writes, behavioural memory responder.
module tb_write_buffer;
  import write_buffer_pkg::*;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  int          vecs = 0;
  int          errs = 0;
  int          lat = 1;
  bit          mem_hold = 1'b0;
  int          we_cycles = 0;
  logic [31:0] mem_model [1024];
  wr_t         wr_q [$];

  write_buffer_if #(.AW(10), .DW(32)) ifc ();

  write_buffer #(.DEPTH(4), .AW(10), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: ready 'lat' cycles after the strobe appears, unless held off.
  initial begin : mem_resp
    int  wcnt;
    wr_t e;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'hFFFF0000 | i;
    ifc.mem_ready = 1'b0;
    ifc.mem_rdata = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst || ifc.mem_ready) begin
        ifc.mem_ready = 1'b0;
        wcnt = 0;
      end else if (ifc.mem_we || ifc.mem_re) begin
        if (ifc.mem_we) we_cycles++;
        wcnt++;
        if (!mem_hold && wcnt >= lat) begin
          ifc.mem_ready = 1'b1;
          if (ifc.mem_we) begin
            vecs++;
            assert (wr_q.size() != 0)
            else begin
              errs++;
              $error("FAIL wr_unexpected: observed write 0x%0h=0x%0h expected none",
                     ifc.mem_addr, ifc.mem_wdata);
            end
            if (wr_q.size() != 0) begin
              e = wr_q.pop_front();
              chk("wr_addr", 64'(ifc.mem_addr), 64'(e.addr));
              chk("wr_data", 64'(ifc.mem_wdata), 64'(e.data));
            end
            mem_model[ifc.mem_addr] = ifc.mem_wdata;
          end else begin
            ifc.mem_rdata = mem_model[ifc.mem_addr];
          end
        end
      end
    end
  end

  task automatic store(input logic [9:0] a, input logic [31:0] d, output int stalls);
    stalls = 0;
    @(negedge clk);
    ifc.cpu_we = 1'b1; ifc.cpu_addr = a; ifc.cpu_wdata = d;
    #2;
    while (ifc.cpu_stall && stalls < 100) begin
      stalls++;
      @(negedge clk); #2;
    end
    chk("store_timeout", 64'(stalls >= 100), 64'd0);
    wr_q.push_back('{addr: a, data: d});
    @(posedge clk); #1;
    ifc.cpu_we = 1'b0;
  endtask

  task automatic load(input logic [9:0] a, output logic [31:0] rd, output int stalls,
                      output int cnt, output bit re_seen);
    stalls = 0; re_seen = 1'b0;
    @(negedge clk);
    ifc.cpu_re = 1'b1; ifc.cpu_addr = a;
    #2;
    while (ifc.cpu_stall && stalls < 100) begin
      if (ifc.mem_re) re_seen = 1'b1;
      stalls++;
      @(negedge clk); #2;
    end
    if (ifc.mem_re) re_seen = 1'b1;
    chk("load_timeout", 64'(stalls >= 100), 64'd0);
    rd  = ifc.cpu_rdata;
    cnt = int'(dut.count);
    @(posedge clk); #1;
    ifc.cpu_re = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    mem_hold = 1'b0;
    while ((dut.count != 0 || ifc.mem_we || ifc.mem_re || wr_q.size() != 0) && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    chk({tag, "_drain_timeout"}, 64'(n >= 200), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          s, c, n, wb;
    logic [31:0] rd;
    bit          re;

    rst = 1'b0;
    ifc.cpu_we = 1'b0; ifc.cpu_re = 1'b0; ifc.cpu_addr = '0; ifc.cpu_wdata = '0;
    #12;
    chk("rst_mem_we",    64'(ifc.mem_we),    64'd0);
    chk("rst_mem_re",    64'(ifc.mem_re),    64'd0);
    chk("rst_mem_addr",  64'(ifc.mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(ifc.mem_wdata), 64'd0);
    chk("rst_cpu_rdata", 64'(ifc.cpu_rdata), 64'd0);
    chk("rst_cpu_stall", 64'(ifc.cpu_stall), 64'd0);
    chk("rst_count",     64'(dut.count),     64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Posted stores: no stall, drained in order.
    lat = 3;
    for (int i = 0; i < 4; i++) begin
      store(10'(32'h010 + i), 32'h0A0 + 32'(i), s);
      chk($sformatf("post_stall_%0d", i), 64'(s), 64'd0);
    end
    drain("post");

    // Full buffer: fifth store stalls, including through the pop cycle.
    lat = 1; mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) store(10'(32'h030 + i), 32'h0C0 + 32'(i), s);
    @(negedge clk);
    ifc.cpu_we = 1'b1; ifc.cpu_addr = 10'h020; ifc.cpu_wdata = 32'hBEEF;
    #2;
    chk("full_stall", 64'(ifc.cpu_stall), 64'd1);
    chk("full_count", 64'(dut.count), 64'd4);
    @(negedge clk); #2;
    chk("full_stall_hold", 64'(ifc.cpu_stall), 64'd1);
    mem_hold = 1'b0;
    @(negedge clk); #2;
    chk("pop_cycle_ready", 64'(ifc.mem_ready), 64'd1);
    chk("stall_on_pop", 64'(ifc.cpu_stall), 64'd1);
    @(negedge clk); #2;
    chk("accept_after_pop", 64'(ifc.cpu_stall), 64'd0);
    chk("count_after_pop", 64'(dut.count), 64'd3);
    wr_q.push_back('{addr: 10'h020, data: 32'hBEEF});
    @(posedge clk); #1;
    ifc.cpu_we = 1'b0;
    drain("full");

    // Load after store to the same address.
    mem_hold = 1'b1;
    store(10'h055, 32'h1234, s);
`ifdef WB_FWD_EN
    load(10'h055, rd, s, c, re);
    chk("fwd_data", 64'(rd), 64'h1234);
    chk("fwd_stall", 64'(s), 64'd0);
    chk("fwd_no_mem_re", 64'(re), 64'd0);
    store(10'h055, 32'h1, s);
    store(10'h055, 32'h2, s);
    load(10'h055, rd, s, c, re);
    chk("fwd_youngest", 64'(rd), 64'h2);
    chk("fwd_youngest_stall", 64'(s), 64'd0);
    drain("fwd");
`else
    fork
      begin
        repeat (3) @(negedge clk);
        #1 mem_hold = 1'b0;
      end
    join_none
    load(10'h055, rd, s, c, re);
    chk("nofwd_data", 64'(rd), 64'h1234);
    chk("nofwd_stalled", 64'(s >= 3), 64'd1);
    chk("nofwd_read_issued", 64'(re), 64'd1);
    drain("nofwd");
`endif

    // Load miss with stores pending: bypasses the second store only when forwarding.
    mem_hold = 1'b1;
    store(10'h060, 32'h6, s);
    store(10'h061, 32'h7, s);
    fork
      begin
        repeat (2) @(negedge clk);
        #1 mem_hold = 1'b0;
      end
    join_none
    load(10'h0AB, rd, s, c, re);
    chk("miss_data", 64'(rd), 64'hFFFF00AB);
`ifdef WB_FWD_EN
    chk("miss_count_at_done", 64'(c), 64'd1);
`else
    chk("miss_count_at_done", 64'(c), 64'd0);
`endif
    chk("rdata_reg", 64'(ifc.cpu_rdata), 64'hFFFF00AB);
    drain("miss");

    // Handshake hold: strobe, address and data stable until ready; pop only on the ready edge.
    lat = 6;
    store(10'h0C0, 32'hDEAD, s);
    n = 0;
    while (!ifc.mem_we && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    chk("hs_start_timeout", 64'(n >= 20), 64'd0);
    wb = 0;
    while (!ifc.mem_ready && wb < 20) begin
      chk("hs_we",    64'(ifc.mem_we),    64'd1);
      chk("hs_addr",  64'(ifc.mem_addr),  64'h0C0);
      chk("hs_data",  64'(ifc.mem_wdata), 64'hDEAD);
      chk("hs_count", 64'(dut.count),     64'd1);
      wb++;
      @(negedge clk); #2;
    end
    chk("hs_wait_cycles", 64'(wb), 64'd5);
    chk("hs_ready_count", 64'(dut.count), 64'd1);
    @(posedge clk); #1;
    chk("hs_popped",  64'(dut.count),  64'd0);
    chk("hs_we_drop", 64'(ifc.mem_we), 64'd0);
    drain("hs");

    // Reset in the middle of a WRITE with three stores buffered.
    lat = 1; mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) store(10'(32'h070 + i), 32'h700 + 32'(i), s);
    @(negedge clk); #2;
    chk("pre_rst_we", 64'(ifc.mem_we), 64'd1);
    chk("pre_rst_count", 64'(dut.count), 64'd3);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_mem_we",    64'(ifc.mem_we),    64'd0);
    chk("mid_rst_mem_re",    64'(ifc.mem_re),    64'd0);
    chk("mid_rst_mem_addr",  64'(ifc.mem_addr),  64'd0);
    chk("mid_rst_mem_wdata", 64'(ifc.mem_wdata), 64'd0);
    chk("mid_rst_cpu_rdata", 64'(ifc.cpu_rdata), 64'd0);
    chk("mid_rst_cpu_stall", 64'(ifc.cpu_stall), 64'd0);
    chk("mid_rst_count",     64'(dut.count),     64'd0);
    wr_q.delete();
    mem_hold = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wb = we_cycles;
    repeat (10) @(negedge clk);
    #2;
    chk("no_we_after_rst", 64'(we_cycles - wb), 64'd0);
    store(10'h0EE, 32'h5A5A, s);
    chk("post_rst_store_stall", 64'(s), 64'd0);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
